// File: rtl/r_burst_response_buffer.sv
// Burst-aware R-beat FIFO between the AXI slave R channel and r_ordering_unit.
// Arbitrary depth, occupancy/burst status, optional store-and-forward and full pass-through.
module r_burst_response_buffer #(
  parameter int unsigned ID_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RESP_WIDTH = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned STORE_FWD  = 0,
  parameter int unsigned FULL_PASS  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  // R beats from the AXI slave
  input  logic                         r_in_valid,
  output logic                         r_in_ready,
  input  logic [ID_WIDTH-1:0]          r_in_id,
  input  logic [DATA_WIDTH-1:0]        r_in_data,
  input  logic [RESP_WIDTH-1:0]        r_in_resp,
  input  logic                         r_in_last,
  // R beats toward r_ordering_unit
  output logic                         r_out_valid,
  input  logic                         r_out_ready,
  output logic [ID_WIDTH-1:0]          r_out_id,
  output logic [DATA_WIDTH-1:0]        r_out_data,
  output logic [RESP_WIDTH-1:0]        r_out_resp,
  output logic                         r_out_last,
  // status
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   bursts,
  output logic                         almost_full,
  output logic                         err_sticky,
  input  logic                         clr_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;

  logic [ENT_W-1:0]      mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]      count_q, count_nxt;
  logic [CNT_W-1:0]      bursts_q, bursts_nxt;
  logic                  err_q, err_nxt;

  logic                  full, empty;
  logic                  push, pop;
  logic                  push_last, pop_last;

  logic [ENT_W-1:0]      head;
  logic [ID_WIDTH-1:0]   head_id;
  logic [DATA_WIDTH-1:0] head_data;
  logic [RESP_WIDTH-1:0] head_resp;
  logic                  head_last;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Pass-through variant: r_out_ready reaches r_in_ready combinationally when full.
  generate
    if (FULL_PASS != 0) begin : g_ready_pass
      assign r_in_ready = ~full | (r_out_valid & r_out_ready);
    end else begin : g_ready_plain
      assign r_in_ready = ~full;
    end
  endgenerate

  // Store-and-forward holds beats until a whole burst is stored; full escape avoids deadlock.
  generate
    if (STORE_FWD != 0) begin : g_valid_sf
      assign r_out_valid = ~empty & ((bursts_q != '0) | full);
    end else begin : g_valid_ct
      assign r_out_valid = ~empty;
    end
  endgenerate

  assign push      = r_in_valid & r_in_ready;
  assign pop       = r_out_valid & r_out_ready;

  assign head      = mem[rd_ptr];
  assign {head_id, head_data, head_resp, head_last} = head;

  assign push_last = push & r_in_last;
  assign pop_last  = pop & head_last;

  // Payload is forced to zero while not valid so unwritten storage never leaks out.
  assign r_out_id    = r_out_valid ? head_id   : '0;
  assign r_out_data  = r_out_valid ? head_data : '0;
  assign r_out_resp  = r_out_valid ? head_resp : '0;
  assign r_out_last  = r_out_valid & head_last;

  assign count       = count_q;
  assign bursts      = bursts_q;
  assign almost_full = (count_q >= CNT_W'(AF_THRESH));
  assign err_sticky  = err_q;

  // Next-state for pointers, occupancy, burst count and sticky error.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count_q;
    bursts_nxt = bursts_q;
    err_nxt    = err_q;

    if (push) begin
      wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase

    case ({push_last, pop_last})
      2'b10:   bursts_nxt = bursts_q + CNT_W'(1);
      2'b01:   bursts_nxt = bursts_q - CNT_W'(1);
      default: bursts_nxt = bursts_q;
    endcase

    // A new error beat takes priority over a clear in the same cycle.
    if (clr_err) begin
      err_nxt = 1'b0;
    end
    if (push && r_in_resp[1]) begin
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      bursts_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count_q  <= count_nxt;
      bursts_q <= bursts_nxt;
      err_q    <= err_nxt;
    end
  end

  // Storage is intentionally not reset; reads are masked by r_out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {r_in_id, r_in_data, r_in_resp, r_in_last};
    end
  end

endmodule

// File: tb/tb_r_burst_response_buffer.sv
// Directed bench for r_burst_response_buffer across five parameter sets
// (plain depth 8 and 5, store-and-forward depth 8 and 4, full pass-through depth 8).
module tb_r_burst_response_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] in_id;
  logic [63:0] in_data;
  logic [1:0]  in_resp;
  logic        in_last;
  logic        clr_err;

  logic        iv    [5];
  logic        ordy  [5];
  logic        ird   [5];
  logic        ov    [5];
  logic [31:0] oid   [5];
  logic [63:0] od    [5];
  logic [1:0]  oresp [5];
  logic        olast [5];
  logic        af    [5];
  logic        err   [5];

  logic [3:0]  cnt_a, cnt_c, cnt_e, bur_a, bur_c, bur_e;
  logic [2:0]  cnt_b, cnt_d, bur_b, bur_d;

  int n_assert = 0;
  int n_fail   = 0;

  r_burst_response_buffer #(.DEPTH(8)) u_a (
    .clk(clk), .rst(rst),
    .r_in_valid(iv[0]), .r_in_ready(ird[0]), .r_in_id(in_id), .r_in_data(in_data),
    .r_in_resp(in_resp), .r_in_last(in_last),
    .r_out_valid(ov[0]), .r_out_ready(ordy[0]), .r_out_id(oid[0]), .r_out_data(od[0]),
    .r_out_resp(oresp[0]), .r_out_last(olast[0]),
    .count(cnt_a), .bursts(bur_a), .almost_full(af[0]), .err_sticky(err[0]), .clr_err(clr_err)
  );

  r_burst_response_buffer #(.DEPTH(5)) u_b (
    .clk(clk), .rst(rst),
    .r_in_valid(iv[1]), .r_in_ready(ird[1]), .r_in_id(in_id), .r_in_data(in_data),
    .r_in_resp(in_resp), .r_in_last(in_last),
    .r_out_valid(ov[1]), .r_out_ready(ordy[1]), .r_out_id(oid[1]), .r_out_data(od[1]),
    .r_out_resp(oresp[1]), .r_out_last(olast[1]),
    .count(cnt_b), .bursts(bur_b), .almost_full(af[1]), .err_sticky(err[1]), .clr_err(clr_err)
  );

  r_burst_response_buffer #(.DEPTH(8), .STORE_FWD(1)) u_c (
    .clk(clk), .rst(rst),
    .r_in_valid(iv[2]), .r_in_ready(ird[2]), .r_in_id(in_id), .r_in_data(in_data),
    .r_in_resp(in_resp), .r_in_last(in_last),
    .r_out_valid(ov[2]), .r_out_ready(ordy[2]), .r_out_id(oid[2]), .r_out_data(od[2]),
    .r_out_resp(oresp[2]), .r_out_last(olast[2]),
    .count(cnt_c), .bursts(bur_c), .almost_full(af[2]), .err_sticky(err[2]), .clr_err(clr_err)
  );

  r_burst_response_buffer #(.DEPTH(4), .STORE_FWD(1)) u_d (
    .clk(clk), .rst(rst),
    .r_in_valid(iv[3]), .r_in_ready(ird[3]), .r_in_id(in_id), .r_in_data(in_data),
    .r_in_resp(in_resp), .r_in_last(in_last),
    .r_out_valid(ov[3]), .r_out_ready(ordy[3]), .r_out_id(oid[3]), .r_out_data(od[3]),
    .r_out_resp(oresp[3]), .r_out_last(olast[3]),
    .count(cnt_d), .bursts(bur_d), .almost_full(af[3]), .err_sticky(err[3]), .clr_err(clr_err)
  );

  r_burst_response_buffer #(.DEPTH(8), .FULL_PASS(1)) u_e (
    .clk(clk), .rst(rst),
    .r_in_valid(iv[4]), .r_in_ready(ird[4]), .r_in_id(in_id), .r_in_data(in_data),
    .r_in_resp(in_resp), .r_in_last(in_last),
    .r_out_valid(ov[4]), .r_out_ready(ordy[4]), .r_out_id(oid[4]), .r_out_data(od[4]),
    .r_out_resp(oresp[4]), .r_out_last(olast[4]),
    .count(cnt_e), .bursts(bur_e), .almost_full(af[4]), .err_sticky(err[4]), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  sent;
    int  npop;
    logic acc;
    logic popn;

    rst     = 1'b0;
    in_id   = '0;
    in_data = '0;
    in_resp = '0;
    in_last = 1'b0;
    clr_err = 1'b0;
    for (int k = 0; k < 5; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",  64'(cnt_a), 64'd0);
    chk("rst_bursts", 64'(bur_a), 64'd0);
    chk("rst_af",     64'(af[0]), 64'd0);
    chk("rst_err",    64'(err[0]), 64'd0);
    chk("rst_valid",  64'(ov[0]), 64'd0);
    chk("rst_data",   od[0], 64'd0);
    chk("rst_ready",  64'(ird[0]), 64'd1);
    chk("rst_ready_pass", 64'(ird[4]), 64'd1);
    rst = 1'b1;
    tick();

    // fill depth-8 FIFO with one 8-beat burst, nothing drained
    in_id = 32'h5;
    iv[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 64'(i);
      in_last = (i == 7);
      tick();
      chk("fill_count", 64'(cnt_a), 64'(i + 1));
      chk("fill_af",    64'(af[0]), 64'(i + 1 >= 6));
      chk("fill_ready", 64'(ird[0]), 64'(i + 1 < 8));
    end
    iv[0]   = 1'b0;
    in_last = 1'b0;
    chk("fill_bursts", 64'(bur_a), 64'd1);
    chk("fill_valid",  64'(ov[0]), 64'd1);
    chk("fill_id",     64'(oid[0]), 64'h5);

    ordy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", od[0], 64'(i));
      chk("drain_last", 64'(olast[0]), 64'(i == 7));
      tick();
    end
    chk("drain_count",  64'(cnt_a), 64'd0);
    chk("drain_bursts", 64'(bur_a), 64'd0);
    chk("drain_valid",  64'(ov[0]), 64'd0);

    // depth-5 streaming, 12 beats through wrapping pointers
    ordy[1] = 1'b1;
    iv[1]   = 1'b1;
    in_data = 64'd100;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("stream_valid", 64'(ov[1]), 64'd1);
      chk("stream_data",  od[1], 64'(100 + k));
      chk("stream_count", 64'(cnt_b), 64'd1);
      if (k < 11) in_data = 64'(100 + k + 1);
      else        iv[1] = 1'b0;
    end
    tick();
    chk("stream_end_count", 64'(cnt_b), 64'd0);
    chk("stream_end_valid", 64'(ov[1]), 64'd0);

    // store-and-forward: nothing leaves until the last beat is stored
    ordy[2] = 1'b1;
    iv[2]   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 64'(200 + i);
      tick();
      chk("sf_hold_valid", 64'(ov[2]), 64'd0);
    end
    in_data = 64'd203;
    in_last = 1'b1;
    #1;
    chk("sf_hold_on_last_push", 64'(ov[2]), 64'd0);
    tick();
    iv[2]   = 1'b0;
    in_last = 1'b0;
    chk("sf_release_valid",  64'(ov[2]), 64'd1);
    chk("sf_release_bursts", 64'(bur_c), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("sf_out_data", od[2], 64'(200 + i));
      chk("sf_out_last", 64'(olast[2]), 64'(i == 3));
      tick();
    end
    chk("sf_end_bursts", 64'(bur_c), 64'd0);
    chk("sf_end_count",  64'(cnt_c), 64'd0);
    chk("sf_end_valid",  64'(ov[2]), 64'd0);

    // depth-4 store-and-forward with a burst longer than the FIFO
    sent    = 0;
    npop    = 0;
    ordy[3] = 1'b1;
    for (int cyc = 0; cyc < 60 && npop < 7; cyc++) begin
      iv[3]   = (sent < 7);
      in_data = 64'(300 + sent);
      in_last = (sent == 6);
      #1;
      acc  = iv[3] & ird[3];
      popn = ov[3];
      if (ov[3]) begin
        chk("esc_data", od[3], 64'(300 + npop));
        chk("esc_last", 64'(olast[3]), 64'(npop == 6));
        if (bur_d == 3'd0) chk("esc_only_when_full", 64'(cnt_d), 64'd4);
      end
      @(posedge clk);
      #1;
      if (acc)  sent++;
      if (popn) npop++;
    end
    iv[3]   = 1'b0;
    in_last = 1'b0;
    chk("esc_all_pushed", 64'(sent), 64'd7);
    chk("esc_all_popped", 64'(npop), 64'd7);
    chk("esc_end_count",  64'(cnt_d), 64'd0);

    // full pass-through: push and pop in the same cycle while full
    iv[4] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 64'(400 + i);
      tick();
    end
    chk("pass_full_count", 64'(cnt_e), 64'd8);
    in_data = 64'd408;
    #1;
    chk("pass_ready_blocked", 64'(ird[4]), 64'd0);
    ordy[4] = 1'b1;
    #1;
    chk("pass_ready_open", 64'(ird[4]), 64'd1);
    chk("pass_head",       od[4], 64'd400);
    tick();
    iv[4] = 1'b0;
    chk("pass_count_held", 64'(cnt_e), 64'd8);
    chk("pass_next_head",  od[4], 64'd401);
    for (int i = 1; i < 9; i++) begin
      chk("pass_drain", od[4], 64'(400 + i));
      tick();
    end
    chk("pass_end_count", 64'(cnt_e), 64'd0);

    // sticky error: set, clear, set-wins-over-clear, then async reset mid-burst
    ordy[0] = 1'b0;
    iv[0]   = 1'b1;
    in_data = 64'd500;
    in_resp = 2'b10;
    #1;
    chk("err_before", 64'(err[0]), 64'd0);
    tick();
    chk("err_set", 64'(err[0]), 64'd1);
    iv[0]   = 1'b0;
    in_resp = 2'b00;
    clr_err = 1'b1;
    tick();
    chk("err_cleared", 64'(err[0]), 64'd0);
    iv[0]   = 1'b1;
    in_resp = 2'b11;
    in_data = 64'd501;
    tick();
    chk("err_set_wins", 64'(err[0]), 64'd1);
    clr_err = 1'b0;
    in_resp = 2'b00;
    in_data = 64'd502;
    in_last = 1'b1;
    tick();
    iv[0]   = 1'b0;
    in_last = 1'b0;
    chk("mid_count",  64'(cnt_a), 64'd3);
    chk("mid_bursts", 64'(bur_a), 64'd1);
    chk("mid_valid",  64'(ov[0]), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count",  64'(cnt_a), 64'd0);
    chk("arst_bursts", 64'(bur_a), 64'd0);
    chk("arst_valid",  64'(ov[0]), 64'd0);
    chk("arst_data",   od[0], 64'd0);
    chk("arst_err",    64'(err[0]), 64'd0);
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
